// File: rtl/xeng_vacc_if.sv
// Stream bundle between the X-engine dump, the vector accumulator and the packetiser.
// Latency/backpressure belong to the modules that use it; this only groups the wires.
interface xeng_vacc_if #(
    parameter int COMP_WIDTH   = 20,
    parameter int ACC_LEN_BITS = 16,
    parameter int MCNT_WIDTH   = 48
);
    localparam int OUT_WIDTH = COMP_WIDTH + ACC_LEN_BITS;

    logic                      sync_in;
    logic [8*COMP_WIDTH-1:0]   din;
    logic                      vld;
    logic [MCNT_WIDTH-1:0]     mcnt;
    logic [ACC_LEN_BITS-1:0]   acc_len;

    logic [8*OUT_WIDTH-1:0]    dout;
    logic                      vld_out;
    logic                      sync_out;
    logic [MCNT_WIDTH-1:0]     mcnt_out;
    logic                      sync_err;

    modport master (
        output sync_in, din, vld, mcnt, acc_len,
        input  dout, vld_out, sync_out, mcnt_out, sync_err
    );

    modport slave (
        input  sync_in, din, vld, mcnt, acc_len,
        output dout, vld_out, sync_out, mcnt_out, sync_err
    );
endinterface

// File: rtl/xeng_vacc.sv
// Sums acc_len X-engine dump frames word-by-word in a BRAM; one integrated frame per acc_len inputs.
// Latency 2 cycles vld -> vld_out; no backpressure: every vld word is taken, downstream must keep up.
module xeng_vacc #(
    parameter int FRAME_LEN    = 528,
    parameter int COMP_WIDTH   = 20,
    parameter int ACC_LEN_BITS = 16,
    parameter int MCNT_WIDTH   = 48
) (
    input logic         clk,
    input logic         rst_n,
    xeng_vacc_if.slave  bus
);
    localparam int OW = COMP_WIDTH + ACC_LEN_BITS;
    localparam int CW = COMP_WIDTH;
    localparam int WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DW = 8 * CW;
    localparam int RW = 8 * OW;
    localparam logic [WW-1:0]           LAST_WORD = WW'(FRAME_LEN - 1);
    localparam logic [ACC_LEN_BITS-1:0] ONE_LEN   = ACC_LEN_BITS'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [WW-1:0]           word_cnt;
    logic [ACC_LEN_BITS-1:0] frame_cnt;
    logic [ACC_LEN_BITS-1:0] acc_len_r;
    logic [ACC_LEN_BITS-1:0] acc_len_in;
    logic [ACC_LEN_BITS-1:0] len_cur;
    logic [MCNT_WIDTH-1:0]   mcnt_r;
    logic [MCNT_WIDTH-1:0]   mcnt_cur;
    logic                    accept;
    logic                    start;
    logic                    word_wrap;
    logic                    is_first;
    logic                    is_last;

    logic                    p1_vld;
    logic                    p1_first;
    logic                    p1_last;
    logic                    p1_w0;
    logic [WW-1:0]           p1_addr;
    logic [DW-1:0]           p1_din;
    logic [MCNT_WIDTH-1:0]   p1_mcnt;

    logic [RW-1:0]           ram [FRAME_LEN];
    logic [RW-1:0]           rd_q;
    logic [RW-1:0]           sum_w;
    logic                    wr_en;

    logic [RW-1:0]           dout_q;
    logic                    vld_out_q;
    logic                    sync_out_q;
    logic [MCNT_WIDTH-1:0]   mcnt_out_q;
    logic                    sync_err_q;

    function automatic logic [OW-1:0] sext(input logic [CW-1:0] c);
        return OW'($signed(c));
    endfunction

    // A sync on the same cycle as vld wins: that word is not word 0.
    assign acc_len_in = (bus.acc_len == '0) ? ONE_LEN : bus.acc_len;
    assign accept     = bus.vld && !bus.sync_in && (state_q != S_IDLE);
    assign start      = (word_cnt == '0) && (frame_cnt == '0);
    assign len_cur    = start ? acc_len_in : acc_len_r;
    assign mcnt_cur   = start ? bus.mcnt : mcnt_r;
    assign is_first   = (frame_cnt == '0);
    assign is_last    = (frame_cnt == (len_cur - ONE_LEN));
    assign word_wrap  = (word_cnt == LAST_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sync_in) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_ARMED: if (bus.vld) state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            frame_cnt <= '0;
            acc_len_r <= '0;
            mcnt_r    <= '0;
        end else if (bus.sync_in) begin
            word_cnt  <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            if (start) begin
                acc_len_r <= acc_len_in;
                mcnt_r    <= bus.mcnt;
            end
            if (word_wrap) begin
                word_cnt  <= '0;
                frame_cnt <= is_last ? '0 : frame_cnt + ONE_LEN;
            end else begin
                word_cnt  <= word_cnt + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld   <= 1'b0;
            p1_first <= 1'b0;
            p1_last  <= 1'b0;
            p1_w0    <= 1'b0;
            p1_addr  <= '0;
            p1_din   <= '0;
            p1_mcnt  <= '0;
        end else begin
            p1_vld <= accept;
            if (accept) begin
                p1_first <= is_first;
                p1_last  <= is_last;
                p1_w0    <= (word_cnt == '0);
                p1_addr  <= word_cnt;
                p1_din   <= bus.din;
                p1_mcnt  <= mcnt_cur;
            end
        end
    end

    // Same address is revisited only a full frame later, so the write-back never races the read.
    assign wr_en = p1_vld && !p1_last;

    always_ff @(posedge clk) begin
        if (accept && !is_first) begin
            rd_q <= ram[word_cnt];
        end
        if (wr_en) begin
            ram[p1_addr] <= sum_w;
        end
    end

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < 8; i++) begin
            sum_w[i*OW +: OW] = p1_first ? sext(p1_din[i*CW +: CW])
                                         : sext(p1_din[i*CW +: CW]) + rd_q[i*OW +: OW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            vld_out_q  <= 1'b0;
            sync_out_q <= 1'b0;
            mcnt_out_q <= '0;
            sync_err_q <= 1'b0;
        end else begin
            vld_out_q  <= p1_vld && p1_last;
            sync_out_q <= p1_vld && p1_last && p1_w0;
            if (p1_vld && p1_last) begin
                dout_q <= sum_w;
                if (p1_w0) begin
                    mcnt_out_q <= p1_mcnt;
                end
            end
            if (bus.sync_in && (word_cnt != '0)) begin
                sync_err_q <= 1'b1;
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.vld_out  = vld_out_q;
    assign bus.sync_out = sync_out_q;
    assign bus.mcnt_out = mcnt_out_q;
    assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_xeng_vacc.sv
// Bench for xeng_vacc: directed + random frames against a list-based integration model.
// Checks data, sync, mcnt, exact 2-cycle latency, sticky sync_err and reset behaviour.
module tb_xeng_vacc;
    localparam int FL = 6;
    localparam int CW = 20;
    localparam int AB = 8;
    localparam int MW = 48;
    localparam int OW = CW + AB;

    typedef logic [8*CW-1:0] din_t;
    typedef logic [8*OW-1:0] dout_t;

    logic clk = 1'b0;
    logic rst_n;

    xeng_vacc_if #(.COMP_WIDTH(CW), .ACC_LEN_BITS(AB), .MCNT_WIDTH(MW)) bus ();

    xeng_vacc #(.FRAME_LEN(FL), .COMP_WIDTH(CW), .ACC_LEN_BITS(AB), .MCNT_WIDTH(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;
    logic [MW-1:0]   mcnt_ctr = 48'h1000;
    logic [AB-1:0]   acc_cfg  = '0;

    din_t            mq[$];
    int              m_len;
    logic [MW-1:0]   m_mcnt0;
    bit              m_armed;
    bit              m_err;
    dout_t           e_dat[$];
    bit              e_sync[$];
    logic [MW-1:0]   e_mcnt[$];
    int              e_cyc[$];
    dout_t           rec[$];
    din_t            t5_data[3*FL];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic din_t fill(input longint v);
        din_t r;
        logic [63:0] t;
        t = v;
        for (int c = 0; c < 8; c++) r[c*CW +: CW] = t[CW-1:0];
        return r;
    endfunction

    function automatic dout_t fillo(input longint v);
        dout_t r;
        logic [63:0] t;
        t = v;
        for (int c = 0; c < 8; c++) r[c*OW +: OW] = t[OW-1:0];
        return r;
    endfunction

    function automatic din_t rnd_din();
        din_t r;
        for (int c = 0; c < 8; c++) r[c*CW +: CW] = CW'($urandom);
        return r;
    endfunction

    // Integration as the list of accepted frames: an output word is the column sum over those frames.
    task automatic model_step(input logic s, input logic v, input din_t d, input logic [MW-1:0] mc);
        int     f;
        int     w;
        longint acc;
        dout_t  o;
        din_t   x;
        if (s) begin
            m_armed = 1;
            if (mq.size() % FL != 0) m_err = 1;
            mq.delete();
        end else if (v && m_armed) begin
            if (mq.size() == 0) begin
                m_len   = (acc_cfg == 0) ? 1 : int'(acc_cfg);
                m_mcnt0 = mc;
            end
            f = mq.size() / FL;
            w = mq.size() % FL;
            mq.push_back(d);
            if (f == m_len - 1) begin
                o = '0;
                for (int c = 0; c < 8; c++) begin
                    acc = 0;
                    for (int ff = 0; ff <= f; ff++) begin
                        x   = mq[ff*FL + w];
                        acc += longint'($signed(x[c*CW +: CW]));
                    end
                    o[c*OW +: OW] = acc[OW-1:0];
                end
                e_dat.push_back(o);
                e_sync.push_back(w == 0);
                e_mcnt.push_back(m_mcnt0);
                e_cyc.push_back(cyc + 1);
            end
            if (mq.size() == m_len * FL) mq.delete();
        end
    endtask

    task automatic check_outputs();
        if (e_cyc.size() > 0 && e_cyc[0] == cyc) begin
            chk("vld_out", bus.vld_out, 1'b1);
            chk("dout", bus.dout, e_dat[0]);
            chk("sync_out", bus.sync_out, e_sync[0]);
            chk("mcnt_out", bus.mcnt_out, e_mcnt[0]);
            void'(e_dat.pop_front());
            void'(e_sync.pop_front());
            void'(e_mcnt.pop_front());
            void'(e_cyc.pop_front());
        end else begin
            chk("vld_out_idle", bus.vld_out, 1'b0);
            chk("sync_out_idle", bus.sync_out, 1'b0);
        end
        chk("sync_err", bus.sync_err, m_err);
        if (bus.vld_out === 1'b1) rec.push_back(bus.dout);
    endtask

    task automatic step(input logic s, input logic v, input din_t d);
        bus.sync_in = s;
        bus.vld     = v;
        bus.din     = d;
        bus.mcnt    = mcnt_ctr;
        bus.acc_len = acc_cfg;
        @(posedge clk);
        cyc++;
        model_step(s, v, d, mcnt_ctr);
        #1;
        check_outputs();
        mcnt_ctr++;
    endtask

    task automatic word(input din_t d, input bit gaps);
        while (gaps && $urandom_range(0, 1) == 0) step(1'b0, 1'b0, rnd_din());
        step(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd_din());
    endtask

    task automatic apply_reset();
        bus.sync_in = 1'b0;
        bus.vld     = 1'b0;
        bus.din     = '0;
        bus.mcnt    = '0;
        bus.acc_len = acc_cfg;
        rst_n = 1'b0;
        #1;
        chk("rst_dout", bus.dout, '0);
        chk("rst_vld_out", bus.vld_out, 1'b0);
        chk("rst_sync_out", bus.sync_out, 1'b0);
        chk("rst_mcnt_out", bus.mcnt_out, '0);
        chk("rst_sync_err", bus.sync_err, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        e_dat.delete();
        e_sync.delete();
        e_mcnt.delete();
        e_cyc.delete();
        m_armed = 0;
        m_err   = 0;
    endtask

    initial begin
        rst_n = 1'b1;
        #2;
        apply_reset();
        idle(3);

        // T1: acc_len 1, components equal to word index, pass-through with 2-cycle latency
        acc_cfg = 8'd1;
        rec.delete();
        step(1'b1, 1'b0, '0);
        for (int f = 0; f < 2; f++)
            for (int w = 0; w < FL; w++) word(fill(w), 1'b0);
        idle(3);
        chk("t1_count", rec.size(), 2 * FL);
        chk("t1_word3", rec[3], fillo(3));

        // T2: +3 then -3 over 4 frames; acc_len changes mid-integration are ignored
        acc_cfg = 8'd4;
        rec.delete();
        step(1'b1, 1'b1, fill(3));
        for (int f = 0; f < 4; f++)
            for (int w = 0; w < FL; w++) word(fill(3), 1'b0);
        for (int f = 0; f < 4; f++)
            for (int w = 0; w < FL; w++) begin
                word(fill(-3), 1'b0);
                if (f == 0 && w == 0) acc_cfg = 8'd2;
            end
        idle(3);
        chk("t2_count", rec.size(), 2 * FL);
        chk("t2_plus", rec[0], fillo(12));
        chk("t2_minus", rec[2*FL-1], fillo(-12));

        // T3: longest integration at full-scale positive and negative inputs
        acc_cfg = 8'd255;
        rec.delete();
        step(1'b1, 1'b0, '0);
        for (int f = 0; f < 255; f++)
            for (int w = 0; w < FL; w++) word(fill(524287), 1'b0);
        for (int f = 0; f < 255; f++)
            for (int w = 0; w < FL; w++) word(fill(-524288), 1'b0);
        idle(3);
        chk("t3_count", rec.size(), 2 * FL);
        chk("t3_max", rec[0], fillo(longint'(255) * 524287));
        chk("t3_min", rec[FL], fillo(-longint'(255) * 524288));

        // T4: sync mid-frame aborts the integration and raises sync_err
        acc_cfg = 8'd4;
        rec.delete();
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 2*FL + 3; i++) word(rnd_din(), 1'b0);
        step(1'b1, 1'b1, rnd_din());
        chk("t4_err", bus.sync_err, 1'b1);
        for (int i = 0; i < 4*FL; i++) word(rnd_din(), 1'b0);
        idle(3);
        chk("t4_count", rec.size(), FL);

        // T5: same random frames with and without gaps
        acc_cfg = 8'd3;
        for (int i = 0; i < 3*FL; i++) t5_data[i] = rnd_din();
        rec.delete();
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3*FL; i++) word(t5_data[i], 1'b0);
        idle(3);
        chk("t5_count_nogap", rec.size(), FL);
        rec.delete();
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3*FL; i++) word(t5_data[i], 1'b1);
        idle(3);
        chk("t5_count_gap", rec.size(), FL);

        // T6: reset mid-integration; nothing comes out until a fresh sync plus a full integration
        acc_cfg = 8'd3;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < FL + 3; i++) word(rnd_din(), 1'b0);
        apply_reset();
        rec.delete();
        for (int i = 0; i < 3*FL; i++) word(rnd_din(), 1'b0);
        idle(3);
        chk("t6_no_out", rec.size(), 0);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3*FL; i++) word(rnd_din(), 1'b1);
        idle(3);
        chk("t6_count", rec.size(), FL);
        chk("drain", e_cyc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
